// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter
// Brief    : Shares one cacheline-adaptor port between icache and dcache
//            miss paths with round-robin tie breaking.
// Revision : 1.0  initial release
// ============================================================================
module pmem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_addr,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,

    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_addr,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_last_d;
    logic                r_cmd_read;
    logic                r_cmd_write;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [LINE_W-1:0]   r_cmd_wdata;

    logic                w_req_i;
    logic                w_req_d;
    logic                w_grant_i;
    logic                w_grant_d;
    logic                w_serving;

    assign w_req_i   = icache_pmem_read;
    assign w_req_d   = dcache_pmem_read | dcache_pmem_write;
    // On a tie the cache that was not served last wins.
    assign w_grant_d = w_req_d & (~w_req_i | ~r_last_d);
    assign w_grant_i = w_req_i & ~w_grant_d;
    assign w_serving = (r_state == ST_SERVE_I) || (r_state == ST_SERVE_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_d    <= 1'b0;
            r_cmd_read  <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ST_SERVE_D;
                        r_cmd_addr  <= dcache_pmem_addr;
                        r_cmd_wdata <= dcache_pmem_wdata;
                        // A simultaneous read+write is illegal; the write wins.
                        r_cmd_write <= dcache_pmem_write;
                        r_cmd_read  <= dcache_pmem_read & ~dcache_pmem_write;
                    end else if (w_grant_i) begin
                        r_state     <= ST_SERVE_I;
                        r_cmd_addr  <= icache_pmem_addr;
                        r_cmd_wdata <= '0;
                        r_cmd_write <= 1'b0;
                        r_cmd_read  <= 1'b1;
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    if (mem_resp) begin
                        r_last_d <= (r_state == ST_SERVE_D);
                        r_state  <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // One dead cycle lets the served cache drop its request.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_read          = w_serving & r_cmd_read;
    assign mem_write         = w_serving & r_cmd_write;
    assign mem_addr          = r_cmd_addr;
    assign mem_wdata         = r_cmd_wdata;

    assign icache_pmem_resp  = (r_state == ST_SERVE_I) & mem_resp;
    assign dcache_pmem_resp  = (r_state == ST_SERVE_D) & mem_resp;
    assign icache_pmem_rdata = mem_rdata;
    assign dcache_pmem_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_arbiter
// Brief    : Directed scenarios plus randomized traffic against a
//            transaction-level arbitration model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pmem_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_addr;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;
    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_addr;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the port, remaining dead cycles, last winner, held command.
    int                m_owner;   // 0 none, 1 icache, 2 dcache
    int                m_cool;
    bit                m_last_d;
    bit                m_read;
    bit                m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;

    pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_pmem_read  (icache_pmem_read),
        .icache_pmem_addr  (icache_pmem_addr),
        .icache_pmem_rdata (icache_pmem_rdata),
        .icache_pmem_resp  (icache_pmem_resp),
        .dcache_pmem_read  (dcache_pmem_read),
        .dcache_pmem_write (dcache_pmem_write),
        .dcache_pmem_addr  (dcache_pmem_addr),
        .dcache_pmem_wdata (dcache_pmem_wdata),
        .dcache_pmem_rdata (dcache_pmem_rdata),
        .dcache_pmem_resp  (dcache_pmem_resp),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_resp          (mem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clock();
        bit ri, rd;
        if (rst) begin
            m_owner = 0; m_cool = 0; m_last_d = 0;
            m_read = 0; m_write = 0; m_addr = '0; m_wdata = '0;
        end else if (m_owner != 0) begin
            if (mem_resp) begin
                m_last_d = (m_owner == 2);
                m_owner  = 0;
                m_cool   = 1;
            end
        end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
        end else begin
            ri = icache_pmem_read;
            rd = dcache_pmem_read || dcache_pmem_write;
            if (rd && (!ri || !m_last_d)) begin
                m_owner = 2;
                m_addr  = dcache_pmem_addr;
                m_wdata = dcache_pmem_wdata;
                m_write = dcache_pmem_write;
                m_read  = !dcache_pmem_write;
            end else if (ri) begin
                m_owner = 1;
                m_addr  = icache_pmem_addr;
                m_wdata = '0;
                m_write = 0;
                m_read  = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        icache_pmem_read = 0; icache_pmem_addr = '0;
        dcache_pmem_read = 0; dcache_pmem_write = 0;
        dcache_pmem_addr = '0; dcache_pmem_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        n_cmp++;
        if ({mem_read, mem_write} !== 2'b00) begin
            n_err++; $display("FAIL reset_cmd: got %b want 00", {mem_read, mem_write});
        end
        n_cmp++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            n_err++; $display("FAIL reset_addr_wdata: got addr %h wdata %h want 0", mem_addr, mem_wdata);
        end
        mem_resp = 1;
        settle();
        n_cmp++;
        if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin
            n_err++; $display("FAIL reset_resp_idle: got %b want 00", {icache_pmem_resp, dcache_pmem_resp});
        end
        tick();
        mem_resp = 0;
    endtask

    task automatic test_icache_read();
        logic [LINE_W-1:0] rd;
        apply_reset();
        icache_pmem_read = 1; icache_pmem_addr = 32'h0000_0060;
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            n_cmp++;
            if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h60) begin
                n_err++; $display("FAIL icache_cmd: got r%b w%b addr %h want r1 w0 addr 60", mem_read, mem_write, mem_addr);
            end
            n_cmp++;
            if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin
                n_err++; $display("FAIL icache_early_resp: got %b want 00", {icache_pmem_resp, dcache_pmem_resp});
            end
            tick();
        end
        rd = rand_line();
        mem_resp = 1; mem_rdata = rd;
        settle();
        n_cmp++;
        if (icache_pmem_resp !== 1'b1 || dcache_pmem_resp !== 1'b0) begin
            n_err++; $display("FAIL icache_resp: got i%b d%b want i1 d0", icache_pmem_resp, dcache_pmem_resp);
        end
        n_cmp++;
        if (icache_pmem_rdata !== rd) begin
            n_err++; $display("FAIL icache_rdata: got %h want %h", icache_pmem_rdata, rd);
        end
        tick();
        mem_resp = 0; icache_pmem_read = 0;
        settle();
        n_cmp++;
        if (mem_read !== 1'b0) begin
            n_err++; $display("FAIL icache_release: got mem_read %b want 0", mem_read);
        end
        tick();
    endtask

    task automatic test_dcache_write();
        logic [LINE_W-1:0] wd;
        wd = {32{8'hA5}};
        apply_reset();
        dcache_pmem_write = 1; dcache_pmem_addr = 32'h8000_0020; dcache_pmem_wdata = wd;
        tick();
        settle();
        n_cmp++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h8000_0020 || mem_wdata !== wd) begin
            n_err++; $display("FAIL dwrite_cmd: got r%b w%b addr %h wdata %h", mem_read, mem_write, mem_addr, mem_wdata);
        end
        dcache_pmem_addr = 32'h1234_5660; dcache_pmem_wdata = rand_line();
        tick();
        tick();
        n_cmp++;
        if (mem_addr !== 32'h8000_0020 || mem_wdata !== wd || mem_write !== 1'b1) begin
            n_err++; $display("FAIL dwrite_stable: got w%b addr %h wdata %h want held command", mem_write, mem_addr, mem_wdata);
        end
        mem_resp = 1;
        settle();
        n_cmp++;
        if (dcache_pmem_resp !== 1'b1 || icache_pmem_resp !== 1'b0) begin
            n_err++; $display("FAIL dwrite_resp: got i%b d%b want i0 d1", icache_pmem_resp, dcache_pmem_resp);
        end
        tick();
        mem_resp = 0; dcache_pmem_write = 0;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_owner;
        apply_reset();
        icache_pmem_read = 1; icache_pmem_addr = 32'h0000_0200;
        dcache_pmem_read = 1; dcache_pmem_addr = 32'h0000_0100;
        exp_owner = 2;
        tick();
        for (int g = 0; g < 4; g++) begin
            settle();
            n_cmp++;
            if (mem_read !== 1'b1 || mem_addr !== ((exp_owner == 2) ? 32'h100 : 32'h200)) begin
                n_err++; $display("FAIL rr_grant%0d: got r%b addr %h want owner %0d", g, mem_read, mem_addr, exp_owner);
            end
            mem_resp = 1;
            settle();
            n_cmp++;
            if (icache_pmem_resp !== (exp_owner == 1) || dcache_pmem_resp !== (exp_owner == 2)) begin
                n_err++; $display("FAIL rr_resp%0d: got i%b d%b want owner %0d", g, icache_pmem_resp, dcache_pmem_resp, exp_owner);
            end
            tick();
            mem_resp = 0;
            settle();
            n_cmp++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                n_err++; $display("FAIL rr_release%0d: got r%b w%b want 00", g, mem_read, mem_write);
            end
            tick();
            tick();
            exp_owner = 3 - exp_owner;
        end
        icache_pmem_read = 0; dcache_pmem_read = 0;
        mem_resp = 1;
        tick();
        mem_resp = 0;
        tick(); tick();
    endtask

    task automatic test_hold_after_resp();
        apply_reset();
        icache_pmem_read = 1; icache_pmem_addr = 32'h0000_0ae0;
        tick();
        mem_resp = 1;
        tick();
        mem_resp = 0;
        tick();
        icache_pmem_read = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            n_cmp++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                n_err++; $display("FAIL hold_no_regrant%0d: got r%b w%b want 00", c, mem_read, mem_write);
            end
            tick();
        end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        dcache_pmem_read = 1; dcache_pmem_addr = 32'h0000_0300;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        dcache_pmem_read = 0;
        mem_resp = 1;
        settle();
        n_cmp++;
        if (mem_read !== 1'b0 || icache_pmem_resp !== 1'b0 || dcache_pmem_resp !== 1'b0) begin
            n_err++; $display("FAIL abort_late_resp: got r%b i%b d%b want 000", mem_read, icache_pmem_resp, dcache_pmem_resp);
        end
        tick();
        mem_resp = 0;
        icache_pmem_read = 1; icache_pmem_addr = 32'h0000_0400;
        dcache_pmem_read = 1; dcache_pmem_addr = 32'h0000_0500;
        tick();
        settle();
        n_cmp++;
        if (mem_read !== 1'b1 || mem_addr !== 32'h500) begin
            n_err++; $display("FAIL abort_tie_to_d: got r%b addr %h want r1 addr 500", mem_read, mem_addr);
        end
        icache_pmem_read = 0; dcache_pmem_read = 0;
        mem_resp = 1;
        tick();
        mem_resp = 0;
        tick(); tick();
    endtask

    task automatic test_rw_conflict();
        apply_reset();
        dcache_pmem_read = 1; dcache_pmem_write = 1; dcache_pmem_addr = 32'h0000_0040;
        dcache_pmem_wdata = rand_line();
        tick();
        settle();
        n_cmp++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h40) begin
            n_err++; $display("FAIL rw_conflict: got r%b w%b addr %h want r0 w1 addr 40", mem_read, mem_write, mem_addr);
        end
        dcache_pmem_read = 0; dcache_pmem_write = 0;
        mem_resp = 1;
        tick();
        mem_resp = 0;
        tick(); tick();
    endtask

    task automatic test_random();
        bit i_resp_prev = 0, d_resp_prev = 0, i_hold = 0, d_hold = 0;
        bit e_rd, e_wr, e_ir, e_dr;
        int mem_wait = -1;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (i_resp_prev) begin
                if ($urandom_range(0, 1) == 1) i_hold = 1; else icache_pmem_read = 0;
            end else if (i_hold) begin
                i_hold = 0; icache_pmem_read = 0;
            end else if (!icache_pmem_read && $urandom_range(0, 2) == 0) begin
                icache_pmem_read = 1;
                icache_pmem_addr = $urandom & 32'hffff_ffe0;
            end
            if (d_resp_prev) begin
                if ($urandom_range(0, 1) == 1) d_hold = 1;
                else begin dcache_pmem_read = 0; dcache_pmem_write = 0; end
            end else if (d_hold) begin
                d_hold = 0; dcache_pmem_read = 0; dcache_pmem_write = 0;
            end else if (!dcache_pmem_read && !dcache_pmem_write && $urandom_range(0, 2) == 0) begin
                dcache_pmem_write = $urandom_range(0, 1);
                dcache_pmem_read  = !dcache_pmem_write;
                dcache_pmem_addr  = $urandom & 32'hffff_ffe0;
                dcache_pmem_wdata = rand_line();
            end
            mem_rdata = rand_line();
            if (m_owner == 0) begin
                mem_wait = -1;
                mem_resp = ($urandom_range(0, 9) == 0);
            end else begin
                if (mem_wait < 0) mem_wait = $urandom_range(0, 5);
                if (mem_wait == 0) mem_resp = 1;
                else begin mem_resp = 0; mem_wait--; end
            end
            settle();
            e_rd = (m_owner != 0) && m_read;
            e_wr = (m_owner != 0) && m_write;
            e_ir = (m_owner == 1) && mem_resp;
            e_dr = (m_owner == 2) && mem_resp;
            n_cmp++;
            if (mem_read !== e_rd || mem_write !== e_wr) begin
                n_err++; $display("FAIL rnd_cmd@%0d: got r%b w%b want r%b w%b", cyc, mem_read, mem_write, e_rd, e_wr);
            end
            n_cmp++;
            if (mem_addr !== m_addr || mem_wdata !== m_wdata) begin
                n_err++; $display("FAIL rnd_addr@%0d: got addr %h want %h (wdata match %b)", cyc, mem_addr, m_addr, mem_wdata === m_wdata);
            end
            n_cmp++;
            if (icache_pmem_resp !== e_ir || dcache_pmem_resp !== e_dr) begin
                n_err++; $display("FAIL rnd_resp@%0d: got i%b d%b want i%b d%b", cyc, icache_pmem_resp, dcache_pmem_resp, e_ir, e_dr);
            end
            n_cmp++;
            if (icache_pmem_rdata !== mem_rdata || dcache_pmem_rdata !== mem_rdata) begin
                n_err++; $display("FAIL rnd_rdata@%0d: rdata pass-through differs from mem_rdata", cyc);
            end
            i_resp_prev = e_ir && !rst;
            d_resp_prev = e_dr && !rst;
            tick();
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_round_robin();
        test_hold_after_resp();
        test_reset_abort();
        test_rw_conflict();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
